// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: sends preamble, MSB-first payload, optional even parity, then an idle gap.
// Outputs are registered from the next-state decode, so data_valid never reaches an output combinationally.
module serial_pattern_tx #(
    parameter int                 DATA_W    = 8,
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PAT       = 4'b1011,
    parameter int                 PARITY_EN = 1,
    parameter int                 GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_A = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
    localparam int MAX_B = (MAX_A > GAP) ? MAX_A : GAP;
    localparam int CNT_W = $clog2(MAX_B) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [DATA_W-1:0]  r_shreg;
    logic [DATA_W-1:0]  w_next_shreg;
    logic               r_par;
    logic               w_next_par;
    logic               w_accept;
    logic [PAT_LEN-1:0] w_pat_sh;
    logic               w_out;
    logic               w_out_valid;

    assign w_accept = (r_state == S_IDLE) && data_ready && data_valid;

    // Next-state, counter and shift-register update
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_shreg = r_shreg;
        w_next_par   = r_par;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_PREAMBLE;
                    w_next_cnt   = CNT_W'(PAT_LEN - 1);
                    w_next_shreg = data_in;
                    w_next_par   = even_parity(data_in);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = S_DATA;
                    w_next_cnt   = CNT_W'(DATA_W - 1);
                end else begin
                    w_next_cnt   = r_cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                w_next_shreg = {r_shreg[DATA_W-2:0], 1'b0};
                if (r_cnt == {CNT_W{1'b0}}) begin
                    if (PARITY_EN != 0) begin
                        w_next_state = S_PARITY;
                    end else if (GAP > 0) begin
                        w_next_state = S_GAP;
                        w_next_cnt   = CNT_W'(GAP - 1);
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (GAP > 0) begin
                    w_next_state = S_GAP;
                    w_next_cnt   = CNT_W'(GAP - 1);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign w_pat_sh = PAT >> w_next_cnt;

    // Serial bit decode for the state being entered
    always_comb begin
        w_out       = 1'b0;
        w_out_valid = 1'b0;
        case (w_next_state)
            S_PREAMBLE: begin
                w_out       = w_pat_sh[0];
                w_out_valid = 1'b1;
            end
            S_DATA: begin
                w_out       = w_next_shreg[DATA_W-1];
                w_out_valid = 1'b1;
            end
            S_PARITY: begin
                w_out       = w_next_par;
                w_out_valid = 1'b1;
            end
            default: begin
                w_out       = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_shreg    <= {DATA_W{1'b0}};
            r_par      <= 1'b0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_shreg    <= w_next_shreg;
            r_par      <= w_next_par;
            out        <= w_out;
            out_valid  <= w_out_valid;
            busy       <= (w_next_state != S_IDLE);
            frame_done <= (r_state != S_IDLE) && (w_next_state == S_IDLE);
            data_ready <= (w_next_state == S_IDLE);
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a per-cycle frame model (queue of expected cycles) checked on every
// falling edge, plus literal expectations on bit streams and timing for default and no-parity/no-gap builds.
module tb_serial_pattern_tx;

    typedef struct packed {
        logic o;
        logic ov;
        logic bsy;
        logic fd;
        logic rdy;
    } exp_t;

    logic       clk;
    logic       rst0, rst1;
    logic [7:0] din0, din1;
    logic       dv0, dv1;
    logic       rdy0, out0, ov0, busy0, fd0;
    logic       rdy1, out1, ov1, busy1, fd1;

    int checks;
    int errors;

    exp_t e0, e1;
    exp_t q0[$];
    exp_t q1[$];
    int   cyc;
    int   t_acc0, t_acc1, n_acc0;
    logic armed;

    logic [15:0] cap0, cap1;
    int          hit0, fd1_cyc;

    serial_pattern_tx u_dut0 (
        .clk(clk), .rst(rst0), .data_in(din0), .data_valid(dv0), .data_ready(rdy0),
        .out(out0), .out_valid(ov0), .busy(busy0), .frame_done(fd0)
    );

    serial_pattern_tx #(.PARITY_EN(0), .GAP(0)) u_dut1 (
        .clk(clk), .rst(rst1), .data_in(din1), .data_valid(dv1), .data_ready(rdy1),
        .out(out1), .out_valid(ov1), .busy(busy1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected cycle idx of a frame: preamble 1011, payload MSB first, parity if pe, then gap.
    function automatic exp_t frame_entry(input logic [7:0] d, input int pe, input int idx);
        exp_t       e;
        logic [3:0] pat;
        logic [3:0] tp;
        logic [7:0] td;
        pat   = 4'b1011;
        e     = '0;
        e.bsy = 1'b1;
        if (idx < 4) begin
            tp   = pat >> (3 - idx);
            e.o  = tp[0];
            e.ov = 1'b1;
        end else if (idx < 12) begin
            td   = d >> (11 - idx);
            e.o  = td[0];
            e.ov = 1'b1;
        end else if (idx < 12 + pe) begin
            e.o  = ^d;
            e.ov = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t idle_entry(input logic done);
        exp_t e;
        e     = '0;
        e.fd  = done;
        e.rdy = 1'b1;
        return e;
    endfunction

    // Reference model: on acceptance the whole frame plus its done cycle is queued
    always @(posedge clk) begin
        logic a0, a1;
        a0 = rst0 && e0.rdy && dv0;
        a1 = rst1 && e1.rdy && dv1;
        if (!rst0) begin
            q0.delete();
            e0 = '0;
        end else begin
            if (a0) begin
                t_acc0 = cyc;
                n_acc0 = n_acc0 + 1;
                for (int i = 0; i < 15; i++) q0.push_back(frame_entry(din0, 1, i));
                q0.push_back(idle_entry(1'b1));
            end
            if (q0.size() > 0) e0 = q0.pop_front();
            else               e0 = idle_entry(1'b0);
        end
        if (!rst1) begin
            q1.delete();
            e1 = '0;
        end else begin
            if (a1) begin
                t_acc1 = cyc;
                for (int i = 0; i < 12; i++) q1.push_back(frame_entry(din1, 0, i));
                q1.push_back(idle_entry(1'b1));
            end
            if (q1.size() > 0) e1 = q1.pop_front();
            else               e1 = idle_entry(1'b0);
        end
        cyc   = cyc + 1;
        armed = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle_check();
        if (armed) begin
            chk("dut0.out",        32'(out0),  32'(e0.o));
            chk("dut0.out_valid",  32'(ov0),   32'(e0.ov));
            chk("dut0.busy",       32'(busy0), 32'(e0.bsy));
            chk("dut0.frame_done", 32'(fd0),   32'(e0.fd));
            chk("dut0.data_ready", 32'(rdy0),  32'(e0.rdy));
            chk("dut1.out",        32'(out1),  32'(e1.o));
            chk("dut1.out_valid",  32'(ov1),   32'(e1.ov));
            chk("dut1.busy",       32'(busy1), 32'(e1.bsy));
            chk("dut1.frame_done", 32'(fd1),   32'(e1.fd));
            chk("dut1.data_ready", 32'(rdy1),  32'(e1.rdy));
            if (ov0 === 1'b1) begin
                cap0 = {cap0[14:0], out0};
                if (cap0[3:0] == 4'b1011) hit0 = cyc;
            end
            if (ov1 === 1'b1) cap1 = {cap1[14:0], out1};
            if (fd1 === 1'b1) fd1_cyc = cyc;
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, output int t);
        int n;
        n = 0;
        while (((k == 0) ? !e0.rdy : !e1.rdy) && n < 50) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        chk("ready_wait_timeout", 32'(n >= 50), 32'd0);
        if (k == 0) begin
            dv0 = 1'b1; din0 = d;
        end else begin
            dv1 = 1'b1; din1 = d;
        end
        @(posedge clk); #1;
        dv0 = 1'b0;
        dv1 = 1'b0;
        t = (k == 0) ? t_acc0 : t_acc1;
    endtask

    task automatic stimulus();
        int   t, t_ff, t_01, n;
        exp_t e;
        logic [12:0] s13;

        rst0 = 1'b0; rst1 = 1'b0;
        dv0 = 1'b1; din0 = 8'hA5;
        dv1 = 1'b1; din1 = 8'h81;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b1; rst1 = 1'b1;
        dv0 = 1'b0; dv1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single A5 frame: bit stream and detector hit at the last preamble bit
        send(0, 8'hA5, t);
        repeat (18) @(posedge clk);
        #1;
        chk("a5_stream", 32'(cap0[12:0]), 32'(13'b1011101001010));
        chk("a5_detect_cycle", 32'(hit0), 32'(t + 4));

        // Back-to-back FF then 01 with data_valid held high
        n = 0;
        while (!e0.rdy && n < 50) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        dv0 = 1'b1; din0 = 8'hFF;
        @(posedge clk); #1;
        t_ff = t_acc0;
        din0 = 8'h01;
        n = 0;
        while (n_acc0 < 3 && n < 40) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        chk("b2b_accept_timeout", 32'(n >= 40), 32'd0);
        t_01 = t_acc0;
        dv0 = 1'b0;
        chk("b2b_period", 32'(t_01 - t_ff), 32'd16);
        repeat (18) @(posedge clk);
        #1;
        chk("b2b_01_stream", 32'(cap0[12:0]), 32'(13'b1011000000011));

        // Busy rejection: 3C offered in cycle t+5 of an A5 frame
        send(0, 8'hA5, t);
        repeat (4) @(posedge clk);
        #1;
        dv0 = 1'b1; din0 = 8'h3C;
        @(posedge clk); #1;
        dv0 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("busy_reject_stream", 32'(cap0[12:0]), 32'(13'b1011101001010));

        // Reset asserted in cycle t+7 aborts the frame
        send(0, 8'hA5, t);
        repeat (6) @(posedge clk);
        #1;
        rst0 = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b1;
        chk("midrst_out_valid", 32'(ov0), 32'd0);
        chk("midrst_frame_done", 32'(fd0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'h5A, t);
        repeat (18) @(posedge clk);
        #1;
        chk("after_rst_stream", 32'(cap0[12:0]), 32'(13'b1011010110100));

        // No-parity, no-gap build with 81
        send(1, 8'h81, t);
        repeat (16) @(posedge clk);
        #1;
        chk("np_stream", 32'(cap1[11:0]), 32'(12'b101110000001));
        chk("np_done_cycle", 32'(fd1_cyc), 32'(t + 13));

        // Pin the model itself against hand-computed frames
        for (int i = 0; i < 13; i++) begin
            e = frame_entry(8'hA5, 1, i);
            s13 = {s13[11:0], e.o};
        end
        chk("model_a5", 32'(s13), 32'(13'b1011101001010));
        e = frame_entry(8'h01, 1, 12);
        chk("model_par_01", 32'({e.o, e.ov}), 32'(2'b11));
        e = frame_entry(8'hFF, 1, 14);
        chk("model_gap", 32'({e.ov, e.bsy}), 32'(2'b01));
    endtask

    initial begin
        checks = 0; errors = 0;
        cyc = 0; t_acc0 = 0; t_acc1 = 0; n_acc0 = 0;
        armed = 1'b0;
        e0 = '0; e1 = '0;
        cap0 = '0; cap1 = '0; hit0 = -1; fd1_cyc = -1;
        rst0 = 1'b0; rst1 = 1'b0;
        dv0 = 1'b0; dv1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
            stimulus();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
